// File: rtl/multicycle_main_control.sv
// Multi-cycle main control FSM for the LEGv8-subset CPU.
// Sequences fetch/decode/execute/memory/write-back/branch and drives the
// datapath strobes. It has a memory-ready handshake with a timeout, and it
// counts retired instructions.
module multicycle_main_control #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [10:0]      opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [1:0]       alu_op,
  output logic             reg2loc,
  output logic             alu_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             illegal_op,
  output logic             mem_timeout,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BRANCH, S_HALTED
  } state_t;

  typedef enum logic [3:0] {
    C_RTYPE, C_ADDI, C_LDUR, C_STUR, C_CBZ, C_CBNZ, C_B, C_HALT, C_ILL
  } op_class_t;

  state_t             state_q, state_d;
  op_class_t          cls_q, class_c;
  logic [WAIT_W-1:0]  wait_q;
  logic [CNT_W-1:0]   retired_q;
  logic               timeout_q;
  logic               retire_c;
  logic               fault_c;

  // Opcode classifier over IR[31:21].
  always_comb begin
    class_c = C_ILL;
    casez (opcode)
      11'b11111000010: class_c = C_LDUR;
      11'b11111000000: class_c = C_STUR;
      11'b10001011000: class_c = C_RTYPE;
      11'b11001011000: class_c = C_RTYPE;
      11'b10001010000: class_c = C_RTYPE;
      11'b10101010000: class_c = C_RTYPE;
      11'b1001000100?: class_c = C_ADDI;
      11'b10110100???: class_c = C_CBZ;
      11'b10110101???: class_c = C_CBNZ;
      11'b000101?????: class_c = C_B;
      11'b11111111111: class_c = C_HALT;
      default:         class_c = C_ILL;
    endcase
  end

  // State, opcode class, wait counter, retire counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RST;
      cls_q     <= C_ILL;
      wait_q    <= '0;
      retired_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) cls_q <= class_c;
      if (state_d != state_q)
        wait_q <= '0;
      else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready)
        wait_q <= wait_q + WAIT_W'(1);
      if (retire_c) retired_q <= retired_q + CNT_W'(1);
      if (fault_c)  timeout_q <= 1'b1;
    end
  end

  // Next-state and control decode. Fetch-complete and branch-taken outputs depend on inputs.
  always_comb begin
    state_d    = state_q;
    alu_op     = 2'b00;
    reg2loc    = 1'b0;
    alu_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    illegal_op = 1'b0;
    retire_c   = 1'b0;
    // A ready arriving in the last allowed cycle still completes the access.
    fault_c    = (state_q == S_FETCH || state_q == S_MEM) && !mem_ready &&
                 (wait_q == WAIT_W'(TIMEOUT - 1));

    case (state_q)
      S_RST: state_d = S_FETCH;

      S_FETCH: begin
        if (fault_c) begin
          state_d = S_HALTED;
        end else begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end
        end
      end

      S_DECODE: begin
        case (class_c)
          C_RTYPE, C_ADDI, C_LDUR, C_STUR: state_d = S_EXEC;
          C_CBZ, C_CBNZ, C_B:              state_d = S_BRANCH;
          C_HALT: begin
            state_d  = S_HALTED;
            retire_c = 1'b1;
          end
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end

      S_EXEC: begin
        alu_op  = (cls_q == C_RTYPE) ? 2'b10 : 2'b00;
        alu_src = (cls_q == C_ADDI || cls_q == C_LDUR || cls_q == C_STUR);
        reg2loc = (cls_q == C_STUR);
        state_d = (cls_q == C_LDUR || cls_q == C_STUR) ? S_MEM : S_WB;
      end

      S_MEM: begin
        alu_src = 1'b1;
        if (fault_c) begin
          state_d = S_HALTED;
        end else begin
          mem_read  = (cls_q == C_LDUR);
          mem_write = (cls_q != C_LDUR);
          if (mem_ready) begin
            if (cls_q == C_LDUR) begin
              state_d = S_WB;
            end else begin
              state_d  = S_FETCH;
              retire_c = 1'b1;
            end
          end
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls_q == C_LDUR);
        alu_op     = (cls_q == C_RTYPE) ? 2'b10 : 2'b00;
        alu_src    = (cls_q != C_RTYPE);
        state_d    = S_FETCH;
        retire_c   = 1'b1;
      end

      S_BRANCH: begin
        alu_op   = 2'b01;
        reg2loc  = 1'b1;
        pc_write = 1'b1;
        pc_src   = (cls_q == C_B) ? 1'b1 : (cls_q == C_CBZ) ? zero : ~zero;
        state_d  = S_FETCH;
        retire_c = 1'b1;
      end

      S_HALTED: state_d = S_HALTED;

      default: state_d = S_RST;
    endcase

    // A reset cycle aborts the instruction in flight and drives no strobes.
    if (rst) begin
      alu_op     = 2'b00;
      reg2loc    = 1'b0;
      alu_src    = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign halted      = (state_q == S_HALTED) && !rst;
  assign mem_timeout = timeout_q && !rst;
  assign retired     = retired_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed self-checking bench for multicycle_main_control.
module tb_multicycle_main_control;

  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned CNT_W   = 32;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_ADDI = 11'b10010001001;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_CBNZ = 11'b10110101011;
  localparam logic [10:0] OP_B    = 11'b00010110011;
  localparam logic [10:0] OP_HALT = 11'b11111111111;

  // ctl = {alu_op[1:0], reg2loc, alu_src, mem_read, mem_write,
  //        mem_to_reg, reg_write, ir_write, pc_write, pc_src, illegal_op}
  localparam logic [11:0] K_IDLE       = 12'h000;
  localparam logic [11:0] K_FETCH_RDY  = 12'h08C;
  localparam logic [11:0] K_FETCH_WAIT = 12'h080;
  localparam logic [11:0] K_ILL        = 12'h001;
  localparam logic [11:0] K_EXEC_R     = 12'h800;
  localparam logic [11:0] K_EXEC_I     = 12'h100;
  localparam logic [11:0] K_EXEC_ST    = 12'h300;
  localparam logic [11:0] K_MEM_LD     = 12'h180;
  localparam logic [11:0] K_MEM_ST     = 12'h140;
  localparam logic [11:0] K_WB_R       = 12'h810;
  localparam logic [11:0] K_WB_I       = 12'h110;
  localparam logic [11:0] K_WB_LD      = 12'h130;
  localparam logic [11:0] K_BR_T       = 12'h606;
  localparam logic [11:0] K_BR_N       = 12'h604;

  logic             clk;
  logic             rst;
  logic [10:0]      opcode;
  logic             zero;
  logic             mem_ready;
  logic [1:0]       alu_op;
  logic             reg2loc, alu_src, mem_read, mem_write, mem_to_reg;
  logic             reg_write, ir_write, pc_write, pc_src, illegal_op;
  logic             mem_timeout, halted;
  logic [CNT_W-1:0] retired;
  logic [11:0]      ctl;

  int               errors = 0;
  int               checks = 0;
  logic [CNT_W-1:0] exp_ret;

  multicycle_main_control #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .alu_op(alu_op), .reg2loc(reg2loc), .alu_src(alu_src), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout), .halted(halted),
    .retired(retired)
  );

  assign ctl = {alu_op, reg2loc, alu_src, mem_read, mem_write,
                mem_to_reg, reg_write, ir_write, pc_write, pc_src, illegal_op};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic test_reset();
    rst = 1'b1; opcode = OP_ADD; zero = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (ctl !== K_IDLE) begin
        errors++; $display("FAIL reset_ctl cyc%0d: got %h want %h", i, ctl, K_IDLE);
      end
    end
    checks++;
    if ({halted, mem_timeout, retired} !== {2'b00, CNT_W'(0)}) begin
      errors++; $display("FAIL reset_flags: halted=%b timeout=%b retired=%0d want 0", halted, mem_timeout, retired);
    end
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if (ctl !== K_IDLE) begin
      errors++; $display("FAIL reset_rst_state_ctl: got %h want %h", ctl, K_IDLE);
    end
    exp_ret = '0;
    @(posedge clk);
  endtask

  task automatic test_rtype();
    logic [10:0] ops [5];
    logic [11:0] e;
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDI};
    for (int n = 0; n < 5; n++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk); opcode = ops[n]; mem_ready = 1'b1; #1;
        case (c)
          0:       e = K_FETCH_RDY;
          1:       e = K_IDLE;
          2:       e = (n == 4) ? K_EXEC_I : K_EXEC_R;
          default: e = (n == 4) ? K_WB_I : K_WB_R;
        endcase
        checks++;
        if (ctl !== e) begin
          errors++; $display("FAIL rtype op%0d cyc%0d: got %h want %h", n, c, ctl, e);
        end
      end
      @(posedge clk); #1;
      exp_ret = exp_ret + CNT_W'(1);
      checks++;
      if (retired !== exp_ret) begin
        errors++; $display("FAIL rtype_retired op%0d: got %0d want %0d", n, retired, exp_ret);
      end
    end
  endtask

  task automatic test_ldur_wait();
    logic [11:0] ev [7];
    logic [6:0]  rdy;
    ev  = '{K_FETCH_RDY, K_IDLE, K_EXEC_I, K_MEM_LD, K_MEM_LD, K_MEM_LD, K_WB_LD};
    rdy = 7'b1100111;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk); opcode = OP_LDUR; mem_ready = rdy[c]; #1;
      checks++;
      if (ctl !== ev[c]) begin
        errors++; $display("FAIL ldur cyc%0d: got %h want %h", c, ctl, ev[c]);
      end
    end
    @(posedge clk); #1;
    exp_ret = exp_ret + CNT_W'(1);
    checks++;
    if (retired !== exp_ret) begin
      errors++; $display("FAIL ldur_retired: got %0d want %0d", retired, exp_ret);
    end
  endtask

  task automatic test_stur();
    logic [11:0] ev [4];
    ev = '{K_FETCH_RDY, K_IDLE, K_EXEC_ST, K_MEM_ST};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); opcode = OP_STUR; mem_ready = 1'b1; #1;
      checks++;
      if (ctl !== ev[c]) begin
        errors++; $display("FAIL stur cyc%0d: got %h want %h", c, ctl, ev[c]);
      end
    end
    @(posedge clk); #1;
    exp_ret = exp_ret + CNT_W'(1);
    checks++;
    if (retired !== exp_ret) begin
      errors++; $display("FAIL stur_retired: got %0d want %0d", retired, exp_ret);
    end
  endtask

  task automatic test_branch();
    logic [10:0] ops [5];
    logic [4:0]  zv;
    logic [11:0] ebr [5];
    logic [11:0] e;
    ops = '{OP_CBZ, OP_CBNZ, OP_B, OP_CBZ, OP_CBNZ};
    zv  = 5'b00011;
    ebr = '{K_BR_T, K_BR_N, K_BR_T, K_BR_N, K_BR_T};
    for (int n = 0; n < 5; n++) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk); opcode = ops[n]; zero = zv[n]; mem_ready = 1'b1; #1;
        e = (c == 0) ? K_FETCH_RDY : (c == 1) ? K_IDLE : ebr[n];
        checks++;
        if (ctl !== e) begin
          errors++; $display("FAIL branch case%0d cyc%0d: got %h want %h", n, c, ctl, e);
        end
      end
      @(posedge clk); #1;
      exp_ret = exp_ret + CNT_W'(1);
      checks++;
      if (retired !== exp_ret) begin
        errors++; $display("FAIL branch_retired case%0d: got %0d want %0d", n, retired, exp_ret);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_timeout_edge();
    logic [11:0] e;
    for (int c = 0; c < 19; c++) begin
      @(negedge clk); opcode = OP_ADD; mem_ready = (c >= 15); #1;
      if (c < 15)       e = K_FETCH_WAIT;
      else if (c == 15) e = K_FETCH_RDY;
      else if (c == 16) e = K_IDLE;
      else if (c == 17) e = K_EXEC_R;
      else              e = K_WB_R;
      checks++;
      if ({mem_timeout, ctl} !== {1'b0, e}) begin
        errors++; $display("FAIL timeout_edge cyc%0d: timeout=%b ctl=%h want 0/%h", c, mem_timeout, ctl, e);
      end
    end
    @(posedge clk); #1;
    exp_ret = exp_ret + CNT_W'(1);
    checks++;
    if (retired !== exp_ret) begin
      errors++; $display("FAIL timeout_edge_retired: got %0d want %0d", retired, exp_ret);
    end
  endtask

  task automatic test_illegal();
    logic [11:0] ev [3];
    ev = '{K_FETCH_RDY, K_ILL, K_FETCH_WAIT};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); opcode = 11'h000; mem_ready = (c == 0); #1;
      checks++;
      if (ctl !== ev[c]) begin
        errors++; $display("FAIL illegal cyc%0d: got %h want %h", c, ctl, ev[c]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (retired !== exp_ret) begin
      errors++; $display("FAIL illegal_retired: got %0d want %0d", retired, exp_ret);
    end
  endtask

  task automatic test_halt();
    logic [11:0] ev [2];
    ev = '{K_FETCH_RDY, K_IDLE};
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); opcode = OP_HALT; mem_ready = 1'b1; #1;
      checks++;
      if (ctl !== ev[c]) begin
        errors++; $display("FAIL halt cyc%0d: got %h want %h", c, ctl, ev[c]);
      end
    end
    exp_ret = exp_ret + CNT_W'(1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); mem_ready = c[0]; zero = c[1]; opcode = OP_ADD; #1;
      checks++;
      if ({halted, ctl} !== {1'b1, K_IDLE}) begin
        errors++; $display("FAIL halted_idle cyc%0d: halted=%b ctl=%h want 1/%h", c, halted, ctl, K_IDLE);
      end
    end
    checks++;
    if (retired !== exp_ret) begin
      errors++; $display("FAIL halt_retired: got %0d want %0d", retired, exp_ret);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; zero = 1'b0; #1;
    exp_ret = '0;
    checks++;
    if ({halted, mem_timeout, retired, ctl} !== {2'b00, exp_ret, K_IDLE}) begin
      errors++; $display("FAIL halt_reset: halted=%b timeout=%b retired=%0d ctl=%h want all 0", halted, mem_timeout, retired, ctl);
    end
    @(posedge clk);
  endtask

  task automatic test_timeout();
    logic [11:0] e;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk); opcode = OP_ADD; mem_ready = 1'b0; #1;
      e = (c < 15) ? K_FETCH_WAIT : K_IDLE;
      checks++;
      if ({mem_timeout, halted, ctl} !== {2'b00, e}) begin
        errors++; $display("FAIL timeout_wait cyc%0d: timeout=%b halted=%b ctl=%h want 0/0/%h", c, mem_timeout, halted, ctl, e);
      end
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); mem_ready = (c != 0); #1;
      checks++;
      if ({mem_timeout, halted, ctl} !== {2'b11, K_IDLE}) begin
        errors++; $display("FAIL timeout_fault cyc%0d: timeout=%b halted=%b ctl=%h want 1/1/%h", c, mem_timeout, halted, ctl, K_IDLE);
      end
    end
    checks++;
    if (retired !== exp_ret) begin
      errors++; $display("FAIL timeout_retired: got %0d want %0d", retired, exp_ret);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if ({mem_timeout, halted, ctl} !== {2'b00, K_IDLE}) begin
      errors++; $display("FAIL timeout_reset: timeout=%b halted=%b ctl=%h want 0/0/%h", mem_timeout, halted, ctl, K_IDLE);
    end
    @(posedge clk);
  endtask

  task automatic test_abort_stur();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); opcode = OP_STUR; mem_ready = 1'b1; #1;
      checks++;
      if (ctl !== ((c == 0) ? K_FETCH_RDY : K_IDLE)) begin
        errors++; $display("FAIL abort_pre cyc%0d: got %h", c, ctl);
      end
    end
    @(negedge clk); rst = 1'b1; #1;
    checks++;
    if (ctl !== K_IDLE) begin
      errors++; $display("FAIL abort_exec_ctl: got %h want %h", ctl, K_IDLE);
    end
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if ({ctl, retired} !== {K_IDLE, CNT_W'(0)}) begin
      errors++; $display("FAIL abort_rst_state: ctl=%h retired=%0d want %h/0", ctl, retired, K_IDLE);
    end
    @(negedge clk); #1;
    checks++;
    if (ctl !== K_FETCH_RDY) begin
      errors++; $display("FAIL abort_refetch: got %h want %h", ctl, K_FETCH_RDY);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_ldur_wait();
    test_stur();
    test_branch();
    test_timeout_edge();
    test_illegal();
    test_halt();
    test_timeout();
    test_abort_stur();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
